// File: rtl/sram_axi_bridge.sv
// Bridges the cache's instruction and data SRAM-like ports onto one AXI3 master.
// One single-beat transaction in flight; the data port wins arbitration.
module sram_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        src_data_q, src_data_d;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [31:0] inst_rdata_q, inst_rdata_d, data_rdata_q, data_rdata_d;
  logic        inst_dok_q, inst_dok_d, data_dok_q, data_dok_d;
  logic        grant_data, grant_inst;
  logic        unused_inputs;

  function automatic logic [3:0] wr_strobe(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd0:    return 4'b0001 << a;
      2'd1:    return 4'b0011 << {a[1], 1'b0};
      2'd2:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  assign grant_data = (state_q == S_IDLE) && data_req;
  assign grant_inst = (state_q == S_IDLE) && !data_req && inst_req;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    src_data_d   = src_data_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_dok_d   = 1'b0;
    data_dok_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_data) begin
          addr_d     = data_addr;
          size_d     = data_size;
          wdata_d    = data_wdata;
          src_data_d = 1'b1;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          state_d    = data_wr ? S_WR_REQ : S_RD_ADDR;
        end else if (grant_inst) begin
          addr_d     = inst_addr;
          size_d     = inst_size;
          src_data_d = 1'b0;
          state_d    = S_RD_ADDR;
        end
      end
      S_RD_ADDR: if (arready) state_d = S_RD_DATA;
      S_RD_DATA: begin
        if (rvalid) begin
          if (src_data_q) begin
            data_rdata_d = rdata;
            data_dok_d   = 1'b1;
          end else begin
            inst_rdata_d = rdata;
            inst_dok_d   = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      S_WR_REQ: begin
        // AW and W complete independently; leave once both are done, even in the same cycle.
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (bvalid) begin
          data_dok_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      inst_dok_q   <= 1'b0;
      data_dok_q   <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      inst_dok_q   <= inst_dok_d;
      data_dok_q   <= data_dok_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q     <= addr_d;
    size_q     <= size_d;
    wdata_q    <= wdata_d;
    src_data_q <= src_data_d;
  end

  assign inst_addr_ok = grant_inst && !rst;
  assign data_addr_ok = grant_data && !rst;
  assign inst_data_ok = inst_dok_q;
  assign data_data_ok = data_dok_q;
  assign inst_rdata   = inst_rdata_q;
  assign data_rdata   = data_rdata_q;

  assign arid    = src_data_q ? DATA_ID : INST_ID;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = (state_q == S_RD_ADDR);
  assign rready  = (state_q == S_RD_DATA);

  assign awid    = DATA_ID;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, size_q};
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign awvalid = (state_q == S_WR_REQ) && !aw_done_q;
  assign wid     = DATA_ID;
  assign wdata   = wdata_q;
  assign wstrb   = wr_strobe(size_q, addr_q[1:0]);
  assign wlast   = 1'b1;
  assign wvalid  = (state_q == S_WR_REQ) && !w_done_q;
  assign bready  = (state_q == S_WR_RESP);

  assign unused_inputs = ^{inst_wr, inst_wdata, rid, rresp, rlast, bid, bresp};

endmodule
